// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, Status/Cause bit positions,
// register addresses and the exception sequencer state encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_BEV   = 22;
    localparam int CAUSE_IP_LO  = 8;

    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    // Bit positions inside the WB exception flag vector
    localparam int EXF_ADEL_FETCH = 0;
    localparam int EXF_RI         = 1;
    localparam int EXF_OV         = 2;
    localparam int EXF_SYS        = 3;
    localparam int EXF_BP         = 4;
    localparam int EXF_ADEL_LOAD  = 5;
    localparam int EXF_ADES       = 6;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        BVA_NONE,
        BVA_PC,
        BVA_DATA
    } bva_sel_t;

endpackage

// File: rtl/except_ctrl_if.sv
// Bundle of WB, CP0, commit and fetch-redirect signals around the
// exception sequencer; the sequencer is the slave side.
interface except_ctrl_if;

    logic        wb_valid;
    logic [6:0]  wb_exc;
    logic        wb_eret;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic [31:0] wb_data_addr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        c0_except;
    logic        c0_eret_flush;
    logic [4:0]  c0_excode;
    logic        c0_bd;
    logic [31:0] c0_pc;
    logic [31:0] c0_badvaddr;
    logic        wb_kill;
    logic        flush;
    logic        pipe_drained;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;

    modport slave (
        input  wb_valid, wb_exc, wb_eret, wb_bd, wb_pc, wb_data_addr,
        input  cp0_status, cp0_cause, cp0_epc, pipe_drained, redirect_ack,
        output c0_except, c0_eret_flush, c0_excode, c0_bd, c0_pc, c0_badvaddr,
        output wb_kill, flush, redirect_valid, redirect_pc
    );

    modport master (
        output wb_valid, wb_exc, wb_eret, wb_bd, wb_pc, wb_data_addr,
        output cp0_status, cp0_cause, cp0_epc, pipe_drained, redirect_ack,
        input  c0_except, c0_eret_flush, c0_excode, c0_bd, c0_pc, c0_badvaddr,
        input  wb_kill, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority selector between a pending interrupt and the WB
// exception flags; reports the winning excode and BadVAddr source.
module exc_prio_enc
    import cp0_pkg::*;
(
    input  logic       int_pend,
    input  logic [6:0] exc,
    output logic       taken,
    output logic [4:0] excode,
    output bva_sel_t   bva_sel
);

    // Interrupts outrank everything; AdEL-fetch outranks decode faults
    // because the instruction word itself is garbage.
    always_comb begin
        taken   = 1'b1;
        excode  = EXC_INT;
        bva_sel = BVA_NONE;
        if (int_pend) begin
            excode = EXC_INT;
        end else if (exc[EXF_ADEL_FETCH]) begin
            excode  = EXC_ADEL;
            bva_sel = BVA_PC;
        end else if (exc[EXF_RI]) begin
            excode = EXC_RI;
        end else if (exc[EXF_OV]) begin
            excode = EXC_OV;
        end else if (exc[EXF_SYS]) begin
            excode = EXC_SYS;
        end else if (exc[EXF_BP]) begin
            excode = EXC_BP;
        end else if (exc[EXF_ADEL_LOAD]) begin
            excode  = EXC_ADEL;
            bva_sel = BVA_DATA;
        end else if (exc[EXF_ADES]) begin
            excode  = EXC_ADES;
            bva_sel = BVA_DATA;
        end else begin
            taken = 1'b0;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer: commits the winning event to CP0, then
// flushes the pipeline and hands a redirect target to fetch.
module except_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] VEC_BEV1  = 32'hBFC0_0380,
    parameter logic [31:0] VEC_BEV0  = 32'h8000_0180,
    parameter int          FLUSH_MIN = 2
)(
    input  logic           clk,
    input  logic           reset,
    except_ctrl_if.slave   bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_MIN - 1);

    state_t      state;
    logic [31:0] target;
    logic [3:0]  cnt;
    logic        flush_q;
    logic        redir_q;

    logic        int_pend;
    logic        enc_taken;
    logic [4:0]  enc_excode;
    bva_sel_t    enc_bva_sel;
    logic        live;
    logic        take_exc;
    logic        take_eret;
    logic        unused_cp0;

    assign int_pend = bus.cp0_status[STATUS_IE] & ~bus.cp0_status[STATUS_EXL]
                    & |(bus.cp0_cause[CAUSE_IP_LO +: 8] & bus.cp0_status[STATUS_IM_LO +: 8]);

    assign unused_cp0 = ^{bus.cp0_status[31:23], bus.cp0_status[21:16],
                          bus.cp0_status[7:2], bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

    exc_prio_enc u_prio (
        .int_pend (int_pend),
        .exc      (bus.wb_exc),
        .taken    (enc_taken),
        .excode   (enc_excode),
        .bva_sel  (enc_bva_sel)
    );

    // Commit strobes are combinational so CP0 latches the event on the
    // same edge the sequencer leaves IDLE; reset forces them quiet.
    assign live      = ~reset & (state == IDLE) & bus.wb_valid;
    assign take_exc  = live & enc_taken;
    assign take_eret = live & bus.wb_eret & ~enc_taken;

    always_comb begin
        bus.c0_except     = take_exc;
        bus.c0_eret_flush = take_eret;
        bus.c0_excode     = take_exc ? enc_excode : 5'd0;
        bus.c0_bd         = take_exc & bus.wb_bd;
        bus.c0_pc         = take_exc ? bus.wb_pc : 32'd0;
        bus.c0_badvaddr   = 32'd0;
        if (take_exc && enc_bva_sel == BVA_PC) begin
            bus.c0_badvaddr = bus.wb_pc;
        end else if (take_exc && enc_bva_sel == BVA_DATA) begin
            bus.c0_badvaddr = bus.wb_data_addr;
        end
        bus.wb_kill = (state == IDLE) ? take_exc : (~reset & bus.wb_valid);
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = target;

    // FLUSH holds for at least FLUSH_MIN cycles and then waits for the
    // pipeline to drain; the target is frozen at event time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            target  <= 32'd0;
            cnt     <= 4'd0;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_exc || take_eret) begin
                        target  <= take_exc ? (bus.cp0_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0)
                                            : bus.cp0_epc;
                        cnt     <= FLUSH_LOAD;
                        flush_q <= 1'b1;
                        state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (bus.pipe_drained) begin
                        flush_q <= 1'b0;
                        redir_q <= 1'b1;
                        state   <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ack) begin
                        redir_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    flush_q <= 1'b0;
                    redir_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: commit strobes, flush/redirect timing,
// drain stalls, async reset and interrupt masking.
module tb_except_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    except_ctrl_if bus ();

    except_ctrl #(
        .VEC_BEV1  (32'hBFC0_0380),
        .VEC_BEV0  (32'h8000_0180),
        .FLUSH_MIN (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [6:0] exc, input logic eret,
                                  input logic bd, input logic [31:0] pc, input logic [31:0] addr);
        bus.wb_valid     = valid;
        bus.wb_exc       = exc;
        bus.wb_eret      = eret;
        bus.wb_bd        = bd;
        bus.wb_pc        = pc;
        bus.wb_data_addr = addr;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cp0_status   = 32'h0;
        bus.cp0_cause    = 32'h0;
        bus.cp0_epc      = 32'h0;
        bus.pipe_drained = 1'b1;
        bus.redirect_ack = 1'b0;
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check_output("rst_except",   {31'd0, bus.c0_except},      32'd0);
        check_output("rst_flush",    {31'd0, bus.flush},          32'd0);
        check_output("rst_redir_v",  {31'd0, bus.redirect_valid}, 32'd0);
        check_output("rst_redir_pc", bus.redirect_pc,             32'd0);
        check_output("rst_kill",     {31'd0, bus.wb_kill},        32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Combinational-only peeks in IDLE: withdraw wb_valid before the edge
        bus.cp0_status = 32'h0040_0000;
        apply_stimulus(1'b1, 7'b0000010, 1'b0, 1'b0, 32'h8000_0040, 32'h1234_5678);
        check_output("ri_excode",   {27'd0, bus.c0_excode}, 32'h0a);
        check_output("ri_badvaddr", bus.c0_badvaddr,        32'h0);
        apply_stimulus(1'b1, 7'b0100000, 1'b0, 1'b0, 32'h8000_0044, 32'h8000_2001);
        check_output("adel_ld_excode", {27'd0, bus.c0_excode}, 32'h04);
        check_output("adel_ld_bva",    bus.c0_badvaddr,        32'h8000_2001);
        apply_stimulus(1'b0, 7'b0100000, 1'b0, 1'b0, 32'h8000_0044, 32'h8000_2001);
        check_output("novalid_except", {31'd0, bus.c0_except}, 32'd0);
        tick();
        check_output("novalid_flush", {31'd0, bus.flush}, 32'd0);

        // AdES store with BEV=1
        apply_stimulus(1'b1, 7'b1000000, 1'b0, 1'b0, 32'h8000_0100, 32'h8000_1003);
        check_output("ades_except", {31'd0, bus.c0_except},     32'd1);
        check_output("ades_kill",   {31'd0, bus.wb_kill},       32'd1);
        check_output("ades_excode", {27'd0, bus.c0_excode},     32'h05);
        check_output("ades_bva",    bus.c0_badvaddr,            32'h8000_1003);
        check_output("ades_pc",     bus.c0_pc,                  32'h8000_0100);
        check_output("ades_eretf",  {31'd0, bus.c0_eret_flush}, 32'd0);
        check_output("ades_flush0", {31'd0, bus.flush},         32'd0);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("ades_flush1", {31'd0, bus.flush},     32'd1);
        check_output("ades_nostrb", {31'd0, bus.c0_except}, 32'd0);
        tick();
        check_output("ades_flush2", {31'd0, bus.flush}, 32'd1);
        tick();
        check_output("ades_flush3", {31'd0, bus.flush},          32'd0);
        check_output("ades_rv",     {31'd0, bus.redirect_valid}, 32'd1);
        check_output("ades_rpc",    bus.redirect_pc,             32'hBFC0_0380);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        check_output("ades_rv_done", {31'd0, bus.redirect_valid}, 32'd0);

        // Interrupt plus Ov in a delay slot, BEV=0
        bus.cp0_status = 32'h0000_0401;
        bus.cp0_cause  = 32'h0000_0400;
        apply_stimulus(1'b1, 7'b0000100, 1'b0, 1'b1, 32'h8000_0200, 32'h0);
        check_output("int_except", {31'd0, bus.c0_except}, 32'd1);
        check_output("int_excode", {27'd0, bus.c0_excode}, 32'h00);
        check_output("int_bd",     {31'd0, bus.c0_bd},     32'd1);
        check_output("int_bva",    bus.c0_badvaddr,        32'h0);
        tick();
        bus.cp0_cause = 32'h0;
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_output("int_rpc", bus.redirect_pc, 32'h8000_0180);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;

        // ERET: target is EPC at event time, later EPC changes ignored
        bus.cp0_status = 32'h0;
        bus.cp0_epc    = 32'hBFC0_1234;
        apply_stimulus(1'b1, 7'h0, 1'b1, 1'b0, 32'h8000_0300, 32'h0);
        check_output("eret_flushstrb", {31'd0, bus.c0_eret_flush}, 32'd1);
        check_output("eret_except",    {31'd0, bus.c0_except},     32'd0);
        check_output("eret_kill",      {31'd0, bus.wb_kill},       32'd0);
        tick();
        bus.cp0_epc = 32'hDEAD_BEEF;
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("eret_pulse_end", {31'd0, bus.c0_eret_flush}, 32'd0);
        check_output("eret_flush",     {31'd0, bus.flush},         32'd1);
        tick();
        tick();
        check_output("eret_rv",  {31'd0, bus.redirect_valid}, 32'd1);
        check_output("eret_rpc", bus.redirect_pc,             32'hBFC0_1234);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;

        // Exception and ERET together: exception wins
        apply_stimulus(1'b1, 7'b0001000, 1'b1, 1'b0, 32'h8000_0400, 32'h0);
        check_output("both_except", {31'd0, bus.c0_except},     32'd1);
        check_output("both_eretf",  {31'd0, bus.c0_eret_flush}, 32'd0);
        check_output("both_excode", {27'd0, bus.c0_excode},     32'h08);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_output("both_rpc", bus.redirect_pc, 32'h8000_0180);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;

        // Drain stall: pipe_drained low for 5 cycles, ack after 3 redirect cycles
        bus.cp0_status   = 32'h0040_0000;
        bus.pipe_drained = 1'b0;
        apply_stimulus(1'b1, 7'b0000001, 1'b0, 1'b0, 32'hBFC0_0003, 32'h5555_0000);
        check_output("fetch_excode", {27'd0, bus.c0_excode}, 32'h04);
        check_output("fetch_bva",    bus.c0_badvaddr,        32'hBFC0_0003);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("stall_f1", {31'd0, bus.flush}, 32'd1);
        tick();
        apply_stimulus(1'b1, 7'b0000010, 1'b0, 1'b0, 32'h8000_0500, 32'h0);
        check_output("stall_f2",      {31'd0, bus.flush},     32'd1);
        check_output("stall_noexc",   {31'd0, bus.c0_except}, 32'd0);
        check_output("stall_killwb",  {31'd0, bus.wb_kill},   32'd1);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.redirect_ack = 1'b1;
        check_output("stall_f3", {31'd0, bus.flush}, 32'd1);
        tick();
        bus.redirect_ack = 1'b0;
        check_output("stall_f4",    {31'd0, bus.flush},          32'd1);
        check_output("stall_f4_rv", {31'd0, bus.redirect_valid}, 32'd0);
        tick();
        bus.pipe_drained = 1'b1;
        check_output("stall_f5", {31'd0, bus.flush}, 32'd1);
        tick();
        apply_stimulus(1'b1, 7'b0000100, 1'b0, 1'b0, 32'h8000_0600, 32'h0);
        check_output("stall_f_end", {31'd0, bus.flush},          32'd0);
        check_output("stall_r1",    {31'd0, bus.redirect_valid}, 32'd1);
        check_output("stall_r1_pc", bus.redirect_pc,             32'hBFC0_0380);
        check_output("stall_r1_ex", {31'd0, bus.c0_except},      32'd0);
        check_output("stall_r1_kl", {31'd0, bus.wb_kill},        32'd1);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("stall_r2",    {31'd0, bus.redirect_valid}, 32'd1);
        check_output("stall_r2_pc", bus.redirect_pc,             32'hBFC0_0380);
        tick();
        bus.redirect_ack = 1'b1;
        check_output("stall_r3",    {31'd0, bus.redirect_valid}, 32'd1);
        check_output("stall_r3_pc", bus.redirect_pc,             32'hBFC0_0380);
        tick();
        bus.redirect_ack = 1'b0;
        check_output("stall_r_end", {31'd0, bus.redirect_valid}, 32'd0);

        // Asynchronous reset while REDIRECT is pending
        apply_stimulus(1'b1, 7'b0010000, 1'b0, 1'b0, 32'h8000_0700, 32'h0);
        check_output("bp_excode", {27'd0, bus.c0_excode}, 32'h09);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_output("rr_rv_before", {31'd0, bus.redirect_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("rr_rv",    {31'd0, bus.redirect_valid}, 32'd0);
        check_output("rr_rpc",   bus.redirect_pc,             32'd0);
        check_output("rr_flush", {31'd0, bus.flush},          32'd0);
        tick();
        reset = 1'b0;
        bus.cp0_status = 32'h0;
        apply_stimulus(1'b1, 7'b0001000, 1'b0, 1'b0, 32'h8000_0800, 32'h0);
        check_output("rr_next_exc",  {31'd0, bus.c0_except}, 32'd1);
        check_output("rr_next_code", {27'd0, bus.c0_excode}, 32'h08);
        tick();
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("rr_next_flush", {31'd0, bus.flush}, 32'd1);
        tick();
        tick();
        check_output("rr_next_rpc", bus.redirect_pc, 32'h8000_0180);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;

        // Masked interrupt (EXL=1), then unmasked; waits for wb_valid
        bus.cp0_status = 32'h0000_0403;
        bus.cp0_cause  = 32'h0000_0400;
        apply_stimulus(1'b1, 7'h0, 1'b0, 1'b0, 32'h8000_0900, 32'h0);
        check_output("mask_noexc", {31'd0, bus.c0_except}, 32'd0);
        check_output("mask_nokill", {31'd0, bus.wb_kill},  32'd0);
        tick();
        check_output("mask_noflush", {31'd0, bus.flush}, 32'd0);
        bus.cp0_status = 32'h0000_0401;
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h8000_0904, 32'h0);
        check_output("int_wait", {31'd0, bus.c0_except}, 32'd0);
        tick();
        apply_stimulus(1'b1, 7'h0, 1'b0, 1'b0, 32'h8000_0908, 32'h0);
        check_output("unmask_exc",  {31'd0, bus.c0_except}, 32'd1);
        check_output("unmask_code", {27'd0, bus.c0_excode}, 32'h00);
        check_output("unmask_pc",   bus.c0_pc,              32'h8000_0908);
        tick();
        bus.cp0_cause = 32'h0;
        apply_stimulus(1'b0, 7'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_output("unmask_rpc", bus.redirect_pc, 32'h8000_0180);
        bus.redirect_ack = 1'b1;
        tick();
        bus.redirect_ack = 1'b0;
        check_output("unmask_idle", {31'd0, bus.redirect_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception/interrupt sequencer for the CP0 register file. Samples the retiring write-back instruction and the CP0 interrupt state, picks the highest-priority event, and drives the CP0 commit strobes (`wb_except`, `eret_flush`, excode, BD, PC, BadVAddr). It then flushes the pipeline and issues a fetch redirect through a drain/ack handshake. Sits between the WB stage, CP0 and the fetch unit.

## Interface
- `VEC_BEV1`, 32'hBFC0_0380, exception vector when Status.BEV=1
- `VEC_BEV0`, 32'h8000_0180, exception vector when Status.BEV=0
- `FLUSH_MIN`, 2, minimum cycles `flush` stays high (1..15)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `wb_valid`  in  1  instruction present in WB this cycle
- `wb_exc`  in  7  exception flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-load, [6] AdES
- `wb_eret`  in  1  WB instruction is ERET
- `wb_bd`  in  1  WB instruction sits in a delay slot
- `wb_pc`  in  32  WB instruction PC
- `wb_data_addr`  in  32  load/store effective address
- `cp0_status`  in  32  Status read port
- `cp0_cause`  in  32  Cause read port
- `cp0_epc`  in  32  EPC read port
- `c0_except`  out  1  to CP0 `wb_except`
- `c0_eret_flush`  out  1  to CP0 `eret_flush`
- `c0_excode`  out  5  to CP0 `wb_excode`
- `c0_bd`  out  1  to CP0 `wb_bd`
- `c0_pc`  out  32  to CP0 `wb_pc`
- `c0_badvaddr`  out  32  to CP0 `wb_badvaddr`
- `wb_kill`  out  1  suppress WB register-file write this cycle
- `flush`  out  1  clear all pipeline stages
- `pipe_drained`  in  1  pipeline reports empty
- `redirect_valid`  out  1  redirect request to fetch
- `redirect_pc`  out  32  redirect target
- `redirect_ack`  in  1  fetch accepted redirect

## Operation
- Interrupt pending: `int_pend = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0])`.
- Event priority, highest first: interrupt (0x00), AdEL-fetch (0x04, BadVAddr=`wb_pc`), RI (0x0a), Ov (0x0c), Sys (0x08), Bp (0x09), AdEL-load (0x04, BadVAddr=`wb_data_addr`), AdES (0x05, BadVAddr=`wb_data_addr`), ERET.
- Events are taken only in IDLE with `wb_valid`=1. An interrupt with `wb_valid`=0 waits.
- When an exception or interrupt is taken:
  - `c0_except`, `wb_kill` = 1 (combinational, same cycle).
  - `c0_bd`=`wb_bd`, `c0_pc`=`wb_pc`.
  - Target register ← Status.BEV ? `VEC_BEV1` : `VEC_BEV0`.
  - Go to FLUSH.
- ERET (no exception, no interrupt):
  - `c0_eret_flush`=1, `wb_kill`=0.
  - Target ← `cp0_epc`, sampled that cycle.
  - Go to FLUSH.
- `c0_badvaddr` = 0 for excodes other than 0x04/0x05.
- States:
  - IDLE: watches WB as above.
  - FLUSH: `flush`=1; a 4-bit counter loads `FLUSH_MIN`-1 on entry. Go to REDIRECT when counter=0 and `pipe_drained`=1.
  - REDIRECT: `redirect_valid`=1, `redirect_pc`=target. Go to IDLE on `redirect_ack`.
- In FLUSH/REDIRECT: `wb_kill`=`wb_valid`, all `c0_*` strobes are 0, and new events are ignored.
- Reset value of every output: 0; state IDLE; target 0; counter 0.

## Timing
- Commit strobes are combinational from WB/CP0 inputs in IDLE, so CP0 captures the event on the same clock edge.
- `flush` asserts the cycle after the event. Minimum duration is `FLUSH_MIN` cycles, extended while `pipe_drained`=0.
- `redirect_valid`:
  - rises the cycle after FLUSH exit;
  - holds a stable `redirect_pc` until the `redirect_ack` cycle, inclusive;
  - returns to IDLE the following cycle.
- Minimum event-to-event spacing: `FLUSH_MIN`+2 cycles.
- `redirect_ack` while not in REDIRECT: ignored.
- Asynchronous reset mid-FLUSH/REDIRECT: immediately IDLE, outputs 0, pending redirect discarded.
- Exception and ERET in the same cycle: exception wins, and `c0_eret_flush` stays 0.

## Structure
- Shared package `cp0_pkg`:
  - excode constants (INT, ADEL, ADES, RI, OV, SYS, BP);
  - Status/Cause bit positions (IE, EXL, BEV, IM, IP);
  - CR_* register addresses;
  - state enum {IDLE, FLUSH, REDIRECT}.
- Sub-module `exc_prio_enc`: combinational priority encoder. Takes `int_pend` and `wb_exc`; outputs taken, excode, and a badvaddr-source select.

## Test plan
- AdES store: `wb_exc`=7'b1000000, `wb_data_addr`=32'h8000_1003, BEV=1, `FLUSH_MIN`=2, `pipe_drained`=1 → same cycle `c0_except`=1, `c0_excode`=0x05, `c0_badvaddr`=32'h8000_1003; `flush` high 2 cycles; `redirect_pc`=32'hBFC0_0380.
- Interrupt plus Ov, delay slot: Status=32'h0000_0401, Cause.IP[2]=1, `wb_exc`[2]=1, `wb_bd`=1 → excode 0x00, `c0_bd`=1; Ov not reported.
- ERET: `cp0_epc`=32'hBFC0_1234, then EPC changes during FLUSH → `c0_eret_flush` pulse; `redirect_pc` stays 32'hBFC0_1234.
- Drain stall: `pipe_drained` low 5 cycles, `redirect_ack` delayed 3 cycles → `flush` high 5 cycles; `redirect_valid` high 3 cycles with stable PC; a WB exception arriving meanwhile produces no `c0_except` and `wb_kill`=1.
- Reset mid-REDIRECT: assert `reset` asynchronously between edges → all outputs 0 immediately; next event handled normally from IDLE.
- Masked interrupt: IE=1, EXL=1, IP&IM≠0 → no event; clear EXL → taken on the next `wb_valid`.
